// File: rtl/alu4_seq_ctrl.sv
// Generic synchronous FIFO with count-based full/empty tracking.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: in_rdy = !full (no push-through-pop when full); out_vld = !empty.
module fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign in_rdy  = !full;
  assign out_vld = !empty;
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld && !full;
  assign pop     = out_rdy && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Sequencer feeding an external 4-bit ALU from a command FIFO, with accumulator writeback.
// Latency: push at edge N -> ISSUE in cycle N+1 -> res_valid after edge N+2 (1 cmd / 3 cycles peak).
// Backpressure: cmd_ready = !fifo_full; RESP holds results until res_ready, stalling further issue.
module alu4_seq_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_imm,
  input  logic       cmd_wb,
  input  logic       acc_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_z,
  output logic       res_c,
  output logic [3:0] acc,
  output logic       busy
);

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] imm;
    logic       wb;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  cmd_t   fifo_in;
  cmd_t   fifo_head;
  logic   fifo_vld;
  logic   fifo_pop;
  logic   wb_q;

  assign fifo_in  = cmd_t'{op: cmd_op, imm: cmd_imm, wb: cmd_wb};
  assign fifo_pop = (state == IDLE) && fifo_vld;
  assign busy     = (state != IDLE) || fifo_vld;

  fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (cmd_valid),
    .in_rdy  (cmd_ready),
    .in_dat  (fifo_in),
    .out_vld (fifo_vld),
    .out_rdy (fifo_pop),
    .out_dat (fifo_head)
  );

  // ALU operand registers only load on the pop edge, so they hold outside ISSUE.
  // alu_a takes the post-clear accumulator value so ISSUE always sees the live acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      wb_q      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_z     <= 1'b0;
      res_c     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_vld) begin
            state  <= ISSUE;
            alu_a  <= acc_clr ? 4'd0 : acc;
            alu_b  <= fifo_head.imm;
            alu_op <= fifo_head.op;
            wb_q   <= fifo_head.wb;
          end
        end
        ISSUE: begin
          state     <= RESP;
          res_data  <= alu_out;
          res_z     <= alu_z;
          res_c     <= alu_c;
          res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clear has priority over a coinciding writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if ((state == ISSUE) && wb_q) begin
      acc <= alu_out;
    end
  end

endmodule
